// File: rtl/arbiter_packet_mux_if.sv
// Bundle of the channel inputs, arbiter link and registered output port
// of arbiter_packet_mux.
//
// Handshake rule for both the per-channel inputs and the output:
// a beat transfers on a rising clock edge where valid and ready are both
// high. A producer holds valid, data and last stable until that edge.
// The consumer may change ready at any time.
interface arbiter_packet_mux_if #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = $clog2(WIDTH)
);
  logic [WIDTH-1:0]            in_valid;
  logic [WIDTH*DATA_WIDTH-1:0] in_data;
  logic [WIDTH-1:0]            in_last;
  logic [WIDTH-1:0]            in_ready;
  logic [WIDTH-1:0]            arb_requests;
  logic [SEL_WIDTH-1:0]        arb_grant;
  logic                        arb_valid;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_last;
  logic                        out_ready;
  logic                        busy;

  // Environment side: drives the channels, the arbiter result and downstream ready.
  modport master (
    output in_valid, in_data, in_last, arb_grant, arb_valid, out_ready,
    input  in_ready, arb_requests, out_valid, out_data, out_last, busy
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, in_last, arb_grant, arb_valid, out_ready,
    output in_ready, arb_requests, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/arbiter_packet_mux.sv
// Packet-mode mux behind an arbiter. Channel valids form the request
// vector. A grant seen in IDLE locks the mux onto that channel. The whole
// packet is then forwarded through a single registered output stage.
// While locked, the winner's request is held high so the arbiter keeps
// its grant until the last beat is taken. busy is the FSM state (XFER)
// made visible.
module arbiter_packet_mux #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  arbiter_packet_mux_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic [WIDTH-1:0]      in_ready_c;
  logic [WIDTH-1:0]      lock_mask;
  logic                  out_free;

  // The output register can take a beat when empty or being drained this cycle.
  assign out_free = ~out_valid_q | bus.out_ready;

  // One-hot of the locked channel, only while a packet is in flight.
  always_comb begin
    lock_mask = '0;
    if (state_q == XFER) lock_mask[sel_q] = 1'b1;
  end

  // Next-state logic: lock on grant in IDLE, forward beats in XFER.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_ready_c  = '0;

    // A held beat leaves when downstream takes it; a new accept below overrides.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A grant for a channel that is not presenting a beat is ignored.
        if (bus.arb_valid && bus.in_valid[bus.arb_grant]) begin
          sel_d   = bus.arb_grant;
          state_d = XFER;
        end
      end
      XFER: begin
        in_ready_c[sel_q] = out_free;
        if (bus.in_valid[sel_q] && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
          out_last_d  = bus.in_last[sel_q];
          if (bus.in_last[sel_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial packet and held beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.arb_requests = bus.in_valid | lock_mask;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.busy         = (state_q == XFER);
endmodule

// File: doc/arbiter_packet_mux.md
Name: arbiter_packet_mux

Overview:
- Downstream consumer of the packet-mode arbiter.
- Presents N input channel valids to the arbiter as its request vector.
- Latches the arbiter's grant index and forwards the granted channel's whole packet, beat by beat, to one registered valid/ready output.
- Keeps the winning request asserted until the packet's last beat is accepted, so the arbiter holds its grant for the whole packet.

Parameters:
- WIDTH, 8: number of input channels; must be ≥ 2.
- DATA_WIDTH, 32: bits per data beat.
- SEL_WIDTH, log2(WIDTH) (derived, not overridden): width of the grant/select index.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  WIDTH  per-channel beat valid.
- in_data  in  WIDTH*DATA_WIDTH  per-channel beat data; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  WIDTH  per-channel last-beat-of-packet flag.
- in_ready  out  WIDTH  per-channel ready; at most one bit high.
- arb_requests  out  WIDTH  request vector driven to the arbiter.
- arb_grant  in  SEL_WIDTH  arbiter grant index.
- arb_valid  in  1  arbiter grant valid.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_WIDTH  output beat data (registered).
- out_last  out  1  output last flag (registered).
- out_ready  in  1  downstream ready.
- busy  out  1  high while a packet is locked (state XFER).

Behaviour:
- Reset:
  - Asynchronous assert on reset=0, synchronous-style release.
  - On reset: state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0.
  - Reset mid-packet discards the partial packet and any held output beat; no recovery.
- arb_requests[i] = in_valid[i] | (busy & sel==i). Combinational.
- FSM IDLE:
  - in_ready=0.
  - If arb_valid & in_valid[arb_grant]: sel<=arb_grant and go to XFER.
  - Otherwise stay in IDLE.
  - arb_valid with in_valid[arb_grant]=0 is ignored.
- FSM XFER:
  - busy=1. arb_grant and arb_valid are ignored; sel is frozen.
  - in_ready[sel] = ~out_valid | out_ready; all other in_ready bits are 0.
  - Beat accepted = in_valid[sel] & in_ready[sel].
  - On accept: out_data<=in_data[sel], out_last<=in_last[sel], out_valid<=1.
  - Accepted beat with in_last=1: go to IDLE next cycle.
- Output register:
  - If out_valid & out_ready and no new beat is accepted the same cycle: out_valid<=0.
  - While out_valid & ~out_ready: out_data and out_last hold stable and no input beat is accepted.
- Throughput and latency:
  - One beat per cycle sustained with out_ready=1.
  - Latency from grant observed in IDLE to first out_valid: 2 cycles (lock cycle, then accept cycle).
  - One idle bubble cycle between consecutive packets (the IDLE re-lock).
- Single-beat packet (in_last on first beat): lock, accept, return to IDLE.
- in_valid[sel] dropping mid-packet: stay in XFER and wait; the lock is held indefinitely. Upstream must complete the packet.
- Non-granted channels are never accepted, and their in_data may change freely.
- The last beat may still sit in the output register when the FSM returns to IDLE. A new lock may occur, but its first accept still obeys the output-register ready rule.
- No combinational path from out_ready to out_valid/out_data. The only combinational path is out_ready to in_ready.

Test Plan:
1. Reset held low, in_valid=8'b00001010, arb_grant=1, arb_valid=1 → in_ready=0, out_valid=0, busy=0, arb_requests=8'b00001010. Release reset → busy=1 next edge, sel=1.
2. Channel 3 sends a 4-beat packet 0xA0..0xA3 (last on 0xA3) with out_ready=1 → out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, out_last only on 0xA3. First out_valid 2 cycles after grant. busy falls after the last accept.
3. Mid-packet on channel 3, in_valid[3]=0 for 2 cycles while in_valid[5]=1 and arb_grant=5 → arb_requests[3] stays 1, sel stays 3, in_ready[5]=0, no channel-5 beat is emitted.
4. out_ready=0 for 3 cycles mid-packet → out_data frozen, in_ready[sel]=0. Then out_ready=1 → packet resumes with no lost or duplicated beat.
5. Back-to-back single-beat packets on channels 0 and 6 (grant 0 then 6) → beats 0x11 then 0x66 both emitted with out_last=1, exactly one idle cycle between accepts.
6. reset=0 asserted mid-packet with out_valid=1 → out_valid=0 and busy=0 immediately (asynchronous). After release, a new packet on channel 2 is emitted cleanly.
